// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, canonical NOP and the
// default reset/trap vectors (also consumed by the CSR block).
package cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } seq_state_t;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter with synchronous clear and
// increment enable; wraps modulo 2^XLEN.
module retire_counter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            i_clr,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_count
);

    logic [XLEN-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + XLEN'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: sequences fetch/execute against a handshaked
// instruction memory, commits next-PC, traps misaligned targets, counts retires.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            halt,
    output logic            halted,
    output logic            misalign_trap,
    output logic [XLEN-1:0] bad_addr,
    output logic [XLEN-1:0] instret
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_bad_addr;
    logic            r_trap;
    logic            w_commit;
    logic            w_aligned;

    assign w_aligned = is_word_aligned(pc_next[1:0]);

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_commit    = 1'b1;
                    w_state_nxt = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_VEC;
            r_instr    <= NOP_INSTR;
            r_bad_addr <= '0;
            r_trap     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_trap  <= w_commit && !w_aligned;
            if (r_state == S_FETCH && imem_ack) r_instr <= imem_rdata;
            // A misaligned target still retires; only the PC is redirected.
            if (w_commit) begin
                if (w_aligned) begin
                    r_pc <= pc_next;
                end else begin
                    r_pc       <= TRAP_VEC;
                    r_bad_addr <= pc_next;
                end
            end
        end
    end

    retire_counter #(.XLEN(XLEN)) u_retire (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_commit),
        .o_count (instret)
    );

    assign pc            = r_pc;
    assign imem_addr     = r_pc;
    assign instr         = r_instr;
    assign misalign_trap = r_trap;
    assign bad_addr      = r_bad_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: inputs change and outputs
// are sampled on the falling edge, state advances on the rising edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        halt;
    logic        halted;
    logic        misalign_trap;
    logic [31:0] bad_addr;
    logic [31:0] instret;

    int unsigned total;
    int unsigned bad;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    pc_sequencer #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .halt          (halt),
        .halted        (halted),
        .misalign_trap (misalign_trap),
        .bad_addr      (bad_addr),
        .instret       (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Move from S_FETCH to S_EXEC with a single-cycle ack.
    task automatic do_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        halt     = 1'b0;
        pc_next  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        exp_pc   = 32'h0;
        exp_ret  = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", imem_req); end
        total++; if (instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
        total++; if (instret !== 32'h0) begin bad++; $display("FAIL reset_instret got=%h exp=0", instret); end
        total++; if ({instr_valid, halted, misalign_trap} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {instr_valid, halted, misalign_trap}); end
        total++; if (bad_addr !== 32'h0) begin bad++; $display("FAIL reset_bad_addr got=%h exp=0", bad_addr); end
    endtask

    task automatic test_sequence();
        for (int k = 0; k < 2; k++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin bad++; $display("FAIL seq_fetch req=%b addr=%h exp_addr=%h", imem_req, imem_addr, exp_pc); end
            total++; if (instr_valid !== 1'b0 || instret !== exp_ret) begin bad++; $display("FAIL seq_fetch_state valid=%b instret=%h exp_instret=%h", instr_valid, instret, exp_ret); end
            pc_next = exp_pc + 32'd4;
            do_fetch(32'h0010_0093);
            total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL seq_exec valid=%b req=%b exp 1/0", instr_valid, imem_req); end
            total++; if (instr !== 32'h0010_0093) begin bad++; $display("FAIL seq_instr got=%h exp=00100093", instr); end
            @(negedge clk);
            exp_pc  = exp_pc + 32'd4;
            exp_ret = exp_ret + 32'd1;
        end
        total++; if (pc !== 32'h8 || instret !== 32'd2) begin bad++; $display("FAIL seq_end pc=%h instret=%h exp 8/2", pc, instret); end
    endtask

    task automatic test_delayed_ack();
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin bad++; $display("FAIL wait_fetch req=%b addr=%h valid=%b exp 1/8/0", imem_req, imem_addr, instr_valid); end
        end
        pc_next = 32'hC;
        do_fetch(32'h0020_0113);
        total++; if (instr_valid !== 1'b1 || instr !== 32'h0020_0113 || pc !== 32'h8) begin bad++; $display("FAIL wait_exec valid=%b instr=%h pc=%h", instr_valid, instr, pc); end
        @(negedge clk);
        exp_pc = 32'hC; exp_ret = exp_ret + 32'd1;
        total++; if (pc !== exp_pc || instret !== exp_ret) begin bad++; $display("FAIL wait_commit pc=%h instret=%h exp %h/%h", pc, instret, exp_pc, exp_ret); end
    endtask

    task automatic test_stall();
        pc_next = 32'h40;
        do_fetch(32'h0000_0013);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (pc !== exp_pc || instret !== exp_ret || instr_valid !== 1'b1) begin bad++; $display("FAIL stall_hold pc=%h instret=%h valid=%b exp %h/%h/1", pc, instret, instr_valid, exp_pc, exp_ret); end
        end
        stall = 1'b0;
        @(negedge clk);
        exp_pc = 32'h40; exp_ret = exp_ret + 32'd1;
        total++; if (pc !== exp_pc || instret !== exp_ret || imem_req !== 1'b1) begin bad++; $display("FAIL stall_commit pc=%h instret=%h req=%b exp %h/%h/1", pc, instret, imem_req, exp_pc, exp_ret); end
    endtask

    task automatic test_misalign();
        pc_next = 32'h22;
        do_fetch(32'h0000_0013);
        total++; if (misalign_trap !== 1'b0) begin bad++; $display("FAIL trap_early got=%b exp=0", misalign_trap); end
        @(negedge clk);
        exp_ret = exp_ret + 32'd1;
        total++; if (pc !== 32'h100 || imem_addr !== 32'h100) begin bad++; $display("FAIL trap_pc pc=%h addr=%h exp=00000100", pc, imem_addr); end
        total++; if (misalign_trap !== 1'b1 || bad_addr !== 32'h22) begin bad++; $display("FAIL trap_pulse trap=%b bad_addr=%h exp 1/22", misalign_trap, bad_addr); end
        total++; if (instret !== exp_ret) begin bad++; $display("FAIL trap_retire got=%h exp=%h", instret, exp_ret); end
        @(negedge clk);
        total++; if (misalign_trap !== 1'b0 || bad_addr !== 32'h22) begin bad++; $display("FAIL trap_one_cycle trap=%b bad_addr=%h exp 0/22", misalign_trap, bad_addr); end
        exp_pc = 32'h100;
    endtask

    task automatic test_halt();
        pc_next = 32'h10;
        do_fetch(32'h0000_0013);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        total++; if (pc !== 32'h10 || halted !== 1'b1 || instret !== exp_ret + 32'd1) begin bad++; $display("FAIL halt_enter pc=%h halted=%b instret=%h", pc, halted, instret); end
        imem_ack = 1'b1;
        pc_next  = 32'h80;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 32'h10 || instr_valid !== 1'b0) begin bad++; $display("FAIL halt_hold req=%b halted=%b pc=%h valid=%b", imem_req, halted, pc, instr_valid); end
        end
        do_reset();
        total++; if (pc !== 32'h0 || imem_req !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_reset pc=%h req=%b halted=%b exp 0/1/0", pc, imem_req, halted); end
    endtask

    task automatic test_halt_misalign();
        pc_next = 32'h13;
        do_fetch(32'h0000_0013);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        total++; if (pc !== 32'h100 || misalign_trap !== 1'b1 || halted !== 1'b1 || bad_addr !== 32'h13) begin bad++; $display("FAIL halt_trap pc=%h trap=%b halted=%b bad_addr=%h", pc, misalign_trap, halted, bad_addr); end
        do_reset();
    endtask

    task automatic test_reset_in_exec();
        pc_next = 32'h4;
        do_fetch(32'hDEAD_BEEF);
        stall = 1'b1;
        force dut.u_retire.r_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_retire.r_count;
        @(negedge clk);
        total++; if (instret !== 32'hFFFF_FFFF || instr_valid !== 1'b1) begin bad++; $display("FAIL preload instret=%h valid=%b exp ffffffff/1", instret, instr_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        total++; if (pc !== 32'h0 || instret !== 32'h0 || instr !== 32'h0000_0013 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL exec_reset pc=%h instret=%h instr=%h req=%b valid=%b", pc, instret, instr, imem_req, instr_valid); end
    endtask

    task automatic test_wrap();
        pc_next = 32'hFFFF_FFFC;
        do_fetch(32'h0000_0013);
        stall = 1'b1;
        force dut.u_retire.r_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_retire.r_count;
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        total++; if (instret !== 32'h0 || pc !== 32'hFFFF_FFFC || misalign_trap !== 1'b0) begin bad++; $display("FAIL instret_wrap instret=%h pc=%h trap=%b exp 0/fffffffc/0", instret, pc, misalign_trap); end
        pc_next = 32'h0;
        do_fetch(32'h0000_0013);
        @(negedge clk);
        total++; if (pc !== 32'h0 || misalign_trap !== 1'b0 || instret !== 32'h1) begin bad++; $display("FAIL pc_wrap pc=%h trap=%b instret=%h exp 0/0/1", pc, misalign_trap, instret); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; halt = 1'b0; pc_next = 32'h0;
        exp_pc = 32'h0; exp_ret = 32'h0;
        test_reset();
        test_sequence();
        test_delayed_ack();
        test_stall();
        test_misalign();
        test_halt();
        test_halt_misalign();
        test_reset_in_exec();
        do_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
